// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, BCD digit limits and BCD digit-pair
// arithmetic for the MM:SS countdown timer controller.
package timer_pkg;

   // FSM state encoding; 2'd3 is unused and recovers to STOPPED
   localparam logic [1:0] ST_STOPPED = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_EXPIRED = 2'd2;

   localparam logic [2:0] SEC_1_MAX = 3'd5;
   localparam logic [3:0] SEC_0_MAX = 4'd9;
   localparam logic [2:0] MIN_1_MAX = 3'd5;
   localparam logic [3:0] MIN_0_MAX = 4'd9;

   // One two-digit BCD field (tens 0..5, ones 0..9)
   typedef struct packed {
      logic [2:0] tens;
      logic [3:0] ones;
   } bcd_t;

   // +1 with wrap from max back to 00, no carry out
   function automatic bcd_t bcd_inc(input bcd_t v, input logic [2:0] tens_max,
                                    input logic [3:0] ones_max);
      bcd_t r;
      r = v;
      if (v.ones == ones_max) begin
         r.ones = '0;
         r.tens = (v.tens == tens_max) ? 3'd0 : v.tens + 3'd1;
      end else begin
         r.ones = v.ones + 4'd1;
      end
      return r;
   endfunction

   // -1 with wrap from 00 up to max; the caller detects the borrow as v == 0
   function automatic bcd_t bcd_dec(input bcd_t v, input logic [2:0] tens_max,
                                    input logic [3:0] ones_max);
      bcd_t r;
      r = v;
      if (v.ones == 4'd0) begin
         r.ones = ones_max;
         r.tens = (v.tens == 3'd0) ? tens_max : v.tens - 3'd1;
      end else begin
         r.ones = v.ones - 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/timer_ctrl_btn_event.sv
// btn_event: press detector for one debounced active-low button, with
// optional hold-to-repeat.
//   MCLK     in  system clock
//   RESET    in  synchronous active-high reset
//   BT       in  debounced button level, 0 while pressed
//   HOLD_OFF in  forces the repeat counter to 0 (no repeat can start)
//   EVENT    out one-cycle pulse on press and on each repeat
module btn_event #(
   parameter bit          REPEAT_EN    = 1'b0,
   parameter int unsigned REPEAT_DELAY = 12_587_500,
   parameter int unsigned REPEAT_RATE  = 2_517_500
) (
   input  logic MCLK,
   input  logic RESET,
   input  logic BT,
   input  logic HOLD_OFF,
   output logic EVENT
);

   localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
   localparam logic [CNT_W-1:0] CNT_DELAY = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] CNT_RATE  = CNT_W'(REPEAT_RATE);

   logic             r_prev;
   logic [CNT_W-1:0] r_cnt;
   logic             r_rep;
   logic             w_press;
   logic             w_repeat;

   // r_prev resets to 0 so a button held through reset is not a press
   assign w_press = r_prev & ~BT;

   // r_cnt holds cycles since the press (first phase) or since the last
   // repeat (r_rep=1); 0 means no repeat sequence is active
   assign w_repeat = REPEAT_EN & ~BT & ~HOLD_OFF & (r_cnt != '0) &
                     (r_rep ? (r_cnt == CNT_RATE) : (r_cnt == CNT_DELAY));

   assign EVENT = w_press | w_repeat;

   always_ff @(posedge MCLK) begin
      if (RESET) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= BT;
      end
   end

   always_ff @(posedge MCLK) begin
      if (RESET || BT || HOLD_OFF || !REPEAT_EN) begin
         r_cnt <= '0;
         r_rep <= 1'b0;
      end else if (w_press) begin
         r_cnt <= CNT_W'(1);
         r_rep <= 1'b0;
      end else if (w_repeat) begin
         r_cnt <= CNT_W'(1);
         r_rep <= 1'b1;
      end else if ((r_cnt != '0) && (r_cnt != CNT_SAT)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: single-clock MM:SS countdown controller. Owns four BCD digits
// and sequences set (STOPPED), countdown (RUN) and alarm (EXPIRED).
//   MCLK, RESET                 clock, synchronous active-high reset
//   TICK                        1 Hz single-cycle pulse
//   BT_START/CLEAR/SEC/MIN      debounced buttons, 0 while pressed
//   MIN_1, MIN_0, SEC_1, SEC_0  BCD digits to the 7-segment decoders
//   RUNNING, ALARM, BLANK       status; BLANK blinks only while EXPIRED
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY = 12_587_500,
   parameter int unsigned REPEAT_RATE  = 2_517_500,
   parameter int unsigned BLINK_CYC    = 6_293_750
) (
   input  logic       MCLK,
   input  logic       RESET,
   input  logic       TICK,
   input  logic       BT_START,
   input  logic       BT_CLEAR,
   input  logic       BT_SEC,
   input  logic       BT_MIN,
   output logic [2:0] MIN_1,
   output logic [3:0] MIN_0,
   output logic [2:0] SEC_1,
   output logic [3:0] SEC_0,
   output logic       RUNNING,
   output logic       ALARM,
   output logic       BLANK
);

   localparam int unsigned BLINK_W = $clog2(BLINK_CYC + 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);

   logic [1:0]         r_state;
   bcd_t               r_sec;
   bcd_t               r_min;
   logic               r_running;
   logic               r_alarm;
   logic               r_blank;
   logic [BLINK_W-1:0] r_bcnt;

   logic               w_start;
   logic               w_clear;
   logic               w_sec;
   logic               w_min;
   logic               w_hold_off;

   logic [1:0]         w_state_nxt;
   bcd_t               w_sec_nxt;
   bcd_t               w_min_nxt;
   logic               w_blank_nxt;
   logic [BLINK_W-1:0] w_bcnt_nxt;

   bcd_t               w_sec_dec;
   bcd_t               w_min_dec;
   logic               w_time_zero;
   logic               w_dec_zero;

   assign w_hold_off = (r_state == ST_RUN);

   btn_event #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
      u_start (.MCLK(MCLK), .RESET(RESET), .BT(BT_START), .HOLD_OFF(1'b0), .EVENT(w_start));
   btn_event #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
      u_clear (.MCLK(MCLK), .RESET(RESET), .BT(BT_CLEAR), .HOLD_OFF(1'b0), .EVENT(w_clear));
   btn_event #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
      u_sec (.MCLK(MCLK), .RESET(RESET), .BT(BT_SEC), .HOLD_OFF(w_hold_off), .EVENT(w_sec));
   btn_event #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
      u_min (.MCLK(MCLK), .RESET(RESET), .BT(BT_MIN), .HOLD_OFF(w_hold_off), .EVENT(w_min));

   // Countdown by one second; minutes only borrow when seconds were 00
   assign w_sec_dec   = bcd_dec(r_sec, SEC_1_MAX, SEC_0_MAX);
   assign w_min_dec   = (r_sec == '0) ? bcd_dec(r_min, MIN_1_MAX, MIN_0_MAX) : r_min;
   assign w_time_zero = (r_sec == '0) && (r_min == '0);
   assign w_dec_zero  = (w_sec_dec == '0) && (w_min_dec == '0);

   always_comb begin
      w_state_nxt = r_state;
      w_sec_nxt   = r_sec;
      w_min_nxt   = r_min;

      case (r_state)
         ST_STOPPED: begin
            if (w_start && !w_time_zero) begin
               w_state_nxt = ST_RUN;
            end else begin
               if (w_sec) w_sec_nxt = bcd_inc(r_sec, SEC_1_MAX, SEC_0_MAX);
               if (w_min) w_min_nxt = bcd_inc(r_min, MIN_1_MAX, MIN_0_MAX);
            end
         end
         ST_RUN: begin
            // A tick that lands on 00:00 overrides a simultaneous stop
            if (TICK) begin
               w_sec_nxt = w_sec_dec;
               w_min_nxt = w_min_dec;
               if (w_dec_zero)   w_state_nxt = ST_EXPIRED;
               else if (w_start) w_state_nxt = ST_STOPPED;
            end else if (w_start) begin
               w_state_nxt = ST_STOPPED;
            end
         end
         ST_EXPIRED: begin
            if (w_start || w_sec || w_min) w_state_nxt = ST_STOPPED;
         end
         default: begin
            w_state_nxt = ST_STOPPED;
         end
      endcase

      if (w_clear) begin
         w_state_nxt = ST_STOPPED;
         w_sec_nxt   = '0;
         w_min_nxt   = '0;
      end

      // Blink phase restarts on every entry into EXPIRED
      w_blank_nxt = 1'b0;
      w_bcnt_nxt  = '0;
      if ((r_state == ST_EXPIRED) && (w_state_nxt == ST_EXPIRED)) begin
         if (r_bcnt >= BLINK_LAST) begin
            w_blank_nxt = ~r_blank;
            w_bcnt_nxt  = '0;
         end else begin
            w_blank_nxt = r_blank;
            w_bcnt_nxt  = r_bcnt + BLINK_W'(1);
         end
      end
   end

   always_ff @(posedge MCLK) begin
      if (RESET) begin
         r_state   <= ST_STOPPED;
         r_sec     <= '0;
         r_min     <= '0;
         r_running <= 1'b0;
         r_alarm   <= 1'b0;
         r_blank   <= 1'b0;
         r_bcnt    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_sec     <= w_sec_nxt;
         r_min     <= w_min_nxt;
         r_running <= (w_state_nxt == ST_RUN);
         r_alarm   <= (w_state_nxt == ST_EXPIRED);
         r_blank   <= w_blank_nxt;
         r_bcnt    <= w_bcnt_nxt;
      end
   end

   assign MIN_1   = r_min.tens;
   assign MIN_0   = r_min.ones;
   assign SEC_1   = r_sec.tens;
   assign SEC_0   = r_sec.ones;
   assign RUNNING = r_running;
   assign ALARM   = r_alarm;
   assign BLANK   = r_blank;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed scenarios plus randomized button/tick traffic for
// timer_ctrl, checked every cycle against a seconds-and-minutes model.
module tb_timer_ctrl;

   localparam int RD = 8;
   localparam int RR = 4;
   localparam int BC = 3;

   logic       clk;
   logic       rst;
   logic       tick;
   logic       bt_start, bt_clear, bt_sec, bt_min;
   logic [2:0] min_1, sec_1;
   logic [3:0] min_0, sec_0;
   logic       running, alarm, blank;

   int checks = 0;
   int errors = 0;

   timer_ctrl #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR), .BLINK_CYC(BC)) dut (
      .MCLK(clk), .RESET(rst), .TICK(tick),
      .BT_START(bt_start), .BT_CLEAR(bt_clear), .BT_SEC(bt_sec), .BT_MIN(bt_min),
      .MIN_1(min_1), .MIN_0(min_0), .SEC_1(sec_1), .SEC_0(sec_0),
      .RUNNING(running), .ALARM(alarm), .BLANK(blank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // state: 0 stopped, 1 run, 2 expired; time held as plain integers
   int m_min, m_sec, m_state, m_since_entry;
   bit m_blank;
   bit m_valid = 1'b0;
   int prev_lvl[4];
   int held_k[4];

   always @(posedge clk) begin
      logic [3:0] lv;
      bit ev[4];
      int tot;
      int old_state;
      lv = {bt_min, bt_sec, bt_clear, bt_start};
      if (rst) begin
         m_min = 0; m_sec = 0; m_state = 0; m_since_entry = 0; m_blank = 0;
         for (int b = 0; b < 4; b++) begin prev_lvl[b] = 0; held_k[b] = -1; end
         m_valid = 1'b1;
      end else begin
         for (int b = 0; b < 4; b++) begin
            ev[b] = (prev_lvl[b] == 1) && (lv[b] == 1'b0);
            if (b >= 2) begin
               if (lv[b] == 1'b1 || m_state == 1) held_k[b] = -1;
               else if (ev[b]) held_k[b] = 0;
               else if (held_k[b] >= 0) begin
                  held_k[b]++;
                  if (held_k[b] >= RD && (held_k[b] - RD) % RR == 0) ev[b] = 1;
               end
            end
            prev_lvl[b] = int'(lv[b]);
         end
         old_state = m_state;
         tot = m_min * 60 + m_sec;
         case (m_state)
            0: begin
               if (ev[0] && tot != 0) m_state = 1;
               else begin
                  if (ev[2]) m_sec = (m_sec + 1) % 60;
                  if (ev[3]) m_min = (m_min + 1) % 60;
               end
            end
            1: begin
               if (tick) begin
                  tot = tot - 1;
                  m_min = tot / 60; m_sec = tot % 60;
                  if (tot == 0) m_state = 2;
                  else if (ev[0]) m_state = 0;
               end else if (ev[0]) m_state = 0;
            end
            default: begin
               if (ev[0] || ev[2] || ev[3]) m_state = 0;
            end
         endcase
         if (ev[1]) begin m_state = 0; m_min = 0; m_sec = 0; end
         if (m_state == 2 && old_state == 2) m_since_entry++;
         else m_since_entry = 0;
         m_blank = (m_state == 2) ? bit'((m_since_entry / BC) % 2) : 1'b0;
      end
   end

   function automatic logic [16:0] dut_vec();
      return {min_1, min_0, sec_1, sec_0, running, alarm, blank};
   endfunction

   always @(negedge clk) begin
      logic [16:0] expv;
      if (m_valid) begin
         expv = {3'(m_min / 10), 4'(m_min % 10), 3'(m_sec / 10), 4'(m_sec % 10),
                 m_state == 1, m_state == 2, m_blank};
         checks++;
         if (dut_vec() !== expv) begin
            errors++;
            $display("FAIL model_cycle t=%0t actual=%h required=%h", $time, dut_vec(), expv);
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic step();
      @(negedge clk);
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         0: bt_start = v;
         1: bt_clear = v;
         2: bt_sec   = v;
         default: bt_min = v;
      endcase
   endtask

   task automatic press(input int b);
      set_btn(b, 1'b0); step();
      set_btn(b, 1'b1); step();
   endtask

   task automatic check_lit(input string name, input int mm, input int ss,
                            input bit run, input bit alm, input bit blk);
      logic [16:0] expv;
      expv = {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10), run, alm, blk};
      checks++;
      if (dut_vec() !== expv) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, dut_vec(), expv);
      end
   endtask

   localparam int START = 0, CLEAR = 1, SEC = 2, MIN = 3;

   initial begin
      bit blink_exp[7];
      blink_exp = '{0, 0, 0, 1, 1, 1, 0};
      rst = 1'b1; tick = 1'b0;
      bt_start = 1'b0; bt_clear = 1'b1; bt_sec = 1'b1; bt_min = 1'b1;

      // 1. reset with START held
      repeat (3) step();
      rst = 1'b0;
      step();
      check_lit("reset", 0, 0, 0, 0, 0);
      press(SEC);
      repeat (3) step();
      check_lit("start_held_no_run", 0, 1, 0, 0, 0);
      bt_start = 1'b1; step();
      press(START);
      check_lit("start_after_release", 0, 1, 1, 0, 0);
      press(CLEAR);
      check_lit("clear_in_run", 0, 0, 0, 0, 0);

      // 2. set and wrap
      repeat (59) press(SEC);
      check_lit("sec_59", 0, 59, 0, 0, 0);
      press(SEC);
      check_lit("sec_wrap", 0, 0, 0, 0, 0);
      set_btn(MIN, 1'b0);
      repeat (RD + RR * 3 + 1) step();
      set_btn(MIN, 1'b1); step();
      check_lit("min_autorepeat", 5, 0, 0, 0, 0);

      // 3. run with borrow down to expiry
      press(CLEAR);
      repeat (10) press(MIN);
      check_lit("set_10_00", 10, 0, 0, 0, 0);
      press(START);
      tick = 1'b1; step(); tick = 1'b0;
      check_lit("borrow_09_59", 9, 59, 1, 0, 0);
      for (int i = 0; i < 599; i++) begin
         step();
         tick = 1'b1; step(); tick = 1'b0;
      end
      check_lit("expire_00_00", 0, 0, 0, 1, 0);

      // 5. blink pattern, then SEC exits without incrementing
      for (int j = 1; j < 7; j++) begin
         step();
         check_lit("blink", 0, 0, 0, 1, blink_exp[j]);
      end
      press(SEC);
      check_lit("expired_sec_exit", 0, 0, 0, 0, 0);

      // 4. TICK and START together
      press(SEC);
      press(START);
      tick = 1'b1; bt_start = 1'b0; step();
      tick = 1'b0; bt_start = 1'b1;
      check_lit("tick_start_expire", 0, 0, 0, 1, 0);
      step();
      press(START);
      check_lit("expired_start_exit", 0, 0, 0, 0, 0);
      repeat (5) press(SEC);
      press(START);
      tick = 1'b1; bt_start = 1'b0; step();
      tick = 1'b0; bt_start = 1'b1;
      check_lit("tick_start_stop", 0, 4, 0, 0, 0);

      // 6. CLEAR beats TICK; START at 00:00 ignored
      press(CLEAR);
      repeat (3) press(MIN);
      repeat (17) press(SEC);
      press(START);
      check_lit("run_03_17", 3, 17, 1, 0, 0);
      tick = 1'b1; bt_clear = 1'b0; step();
      tick = 1'b0; bt_clear = 1'b1;
      check_lit("clear_priority", 0, 0, 0, 0, 0);
      step();
      press(START);
      check_lit("start_at_zero", 0, 0, 0, 0, 0);

      // randomized traffic against the model
      for (int c = 0; c < 6000; c++) begin
         if ($urandom_range(0, 5) == 0)  bt_start = ~bt_start;
         if (bt_clear ? ($urandom_range(0, 79) == 0) : ($urandom_range(0, 1) == 0))
            bt_clear = ~bt_clear;
         if ($urandom_range(0, 13) == 0) bt_sec = ~bt_sec;
         if ($urandom_range(0, 13) == 0) bt_min = ~bt_min;
         tick = ($urandom_range(0, 2) == 0);
         rst  = ($urandom_range(0, 999) == 0);
         step();
      end
      rst = 1'b0; tick = 1'b0;
      bt_start = 1'b1; bt_clear = 1'b1; bt_sec = 1'b1; bt_min = 1'b1;
      repeat (4) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Synchronous controller for the MM:SS countdown timer on the UP2 board. It takes debounced active-low buttons and a 1 Hz tick pulse. It owns the four BCD digits (tens of minutes, minutes, tens of seconds, seconds) and sequences set, run, pause, expiry and clear. Its BCD outputs drive the existing 7-segment decoders. It replaces the ripple-clocked counter chain and toggle flip-flop with a single-clock FSM.

Parameters:
REPEAT_DELAY, 12_587_500, cycles a SEC/MIN button must stay held before auto-repeat starts (0.5 s at 25.175 MHz).
REPEAT_RATE, 2_517_500, cycles between auto-repeat increments once repeating (0.1 s).
BLINK_CYC, 6_293_750, cycles per half-period of the display blink in EXPIRED.

Ports:
MCLK  in  1  system clock; the only clock.
RESET  in  1  synchronous reset, active-high.
TICK  in  1  one-MCLK-cycle pulse at 1 Hz, synchronous to MCLK.
BT_START  in  1  debounced start/stop button, 0 while pressed.
BT_CLEAR  in  1  debounced clear button, 0 while pressed.
BT_SEC  in  1  debounced add-second button, 0 while pressed.
BT_MIN  in  1  debounced add-minute button, 0 while pressed.
MIN_1  out  3  BCD tens of minutes, 0..5.
MIN_0  out  4  BCD minutes, 0..9.
SEC_1  out  3  BCD tens of seconds, 0..5.
SEC_0  out  4  BCD seconds, 0..9.
RUNNING  out  1  high in RUN.
ALARM  out  1  high in EXPIRED.
BLANK  out  1  display blank request; toggles in EXPIRED, 0 otherwise.

Behaviour:
- All outputs are registered. A press detected at cycle n is visible on the outputs at n+1.
- Press event: the button's previous registered level is 1 and its current level is 0.
- Edge registers reset to 0, so a button held through reset does not produce a press.
- RESET: all digits 0, state STOPPED, RUNNING=0, ALARM=0, BLANK=0, repeat and blink counters 0.
- States:
  - STOPPED (reset state).
  - RUN.
  - EXPIRED.
- Event priority within a cycle: CLEAR > TICK-expiry > START > SEC/MIN.
- CLEAR press, any state: digits go to 00:00, state goes to STOPPED, BLANK=0.
- STOPPED:
  - SEC press/repeat: seconds +1, wrapping 59->00 with no carry into minutes.
  - MIN press/repeat: minutes +1, wrapping 59->00.
  - SEC and MIN in the same cycle: both apply.
  - START press with time != 00:00: go to RUN.
  - START press with time == 00:00: ignored.
  - TICK: ignored.
- RUN:
  - TICK: decrement by 1 s with BCD borrow (SEC_0 9..0, SEC_1 5..0, MIN_0 9..0, MIN_1 5..0).
  - If the result is 00:00, go to EXPIRED in the same cycle.
  - START press: go to STOPPED. If a TICK arrives in the same cycle, the decrement still applies. If that decrement reaches 00:00, EXPIRED wins.
  - SEC/MIN presses are ignored, and their repeat counters are held at 0.
- EXPIRED:
  - Digits stay at 00:00, ALARM=1.
  - BLANK toggles every BLINK_CYC cycles, starting at 0 on entry.
  - Any press of START, SEC or MIN: go to STOPPED with BLANK=0. That press does not also increment.
  - TICK: ignored.
- Auto-repeat (SEC/MIN only):
  - Press gives one immediate increment.
  - While held, a counter runs. At REPEAT_DELAY cycles after the press a repeat increment fires, then one every REPEAT_RATE cycles.
  - Release clears the counter.
  - START and CLEAR never repeat.
- Counters are sized by $clog2 of their max parameter and saturate; they never wrap.

Decomposition:
- Package timer_pkg:
  - state encoding: STOPPED=2'd0, RUN=2'd1, EXPIRED=2'd2; 2'd3 is illegal and recovers to STOPPED.
  - constants SEC_1_MAX=5, SEC_0_MAX=9, MIN_1_MAX=5, MIN_0_MAX=9.
- Sub-module btn_event: edge detect plus optional auto-repeat.
  - Parameters REPEAT_EN, REPEAT_DELAY, REPEAT_RATE.
  - Ports MCLK, RESET, BT (active-low), HOLD_OFF (forces counter clear), EVENT (1-cycle pulse).
  - Four instances: START, CLEAR (REPEAT_EN=0), SEC, MIN (REPEAT_EN=1).

Test Plan:
Bench parameters are REPEAT_DELAY=8, REPEAT_RATE=4, BLINK_CYC=3 unless noted.
1. Reset: hold BT_START=0 through RESET, then release RESET -> outputs 00:00, RUNNING=0, and no transition to RUN until BT_START goes 1 then 0.
2. Set/wrap: 59 SEC presses then 1 more -> 00:59 then 00:00 with minutes unchanged. Hold BT_MIN for 8+4*3 cycles -> minutes = 1+1+3 = 05.
3. Run/borrow: set 10:00, press START, apply 1 TICK -> 09:59, RUNNING=1. Apply 599 more TICKs -> 00:00, ALARM=1, RUNNING=0 in that same cycle.
4. Simultaneous: at 00:01 in RUN, assert TICK and START press in the same cycle -> EXPIRED. At 00:05, the same combination -> STOPPED at 00:04.
5. EXPIRED: BLANK sequence 0,0,0,1,1,1,0 over cycles after entry. SEC press -> STOPPED, digits 00:00, BLANK=0.
6. Clear priority: in RUN at 03:17, CLEAR press with TICK in the same cycle -> 00:00 STOPPED. START at 00:00 -> stays STOPPED.
